dual_issue_scheduler: RTL and testbench

Issue controller for the 2-way in-order superscalar core. It sits between the fetch stage, which delivers instruction pairs, and the two ID/EX lanes. Each cycle it decides whether to issue both instructions, only the older one, or neither. It uses a per-register latency scoreboard, intra-pair RAW/WAW checks and a single-multiplier structural rule.

---
 rtl/dual_issue_scheduler_if.sv | 26 ++
 rtl/dual_issue_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-side pair handshake and issue-lane outputs of the dual-issue scheduler.
// master = fetch / environment side, slave = scheduler.
interface dual_issue_scheduler_if;
    logic        flush;
    logic        stall_in;
    logic        pair_valid;
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic        instr1_valid;
    logic        pair_ready;
    logic        iss0_valid;
    logic [31:0] iss0_ir;
    logic        iss1_valid;
    logic [31:0] iss1_ir;
    logic        hz_stall;

    modport master (
        output flush, stall_in, pair_valid, instr0, instr1, instr1_valid,
        input  pair_ready, iss0_valid, iss0_ir, iss1_valid, iss1_ir, hz_stall
    );

    modport slave (
        input  flush, stall_in, pair_valid, instr0, instr1, instr1_valid,
        output pair_ready, iss0_valid, iss0_ir, iss1_valid, iss1_ir, hz_stall
    );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Two-way in-order issue controller: two-entry pair queue, per-register latency
// scoreboard, intra-pair RAW/WAW checks and a single-multiplier rule.
module dual_issue_scheduler #(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                   clk1,
    input  logic                   reset,
    dual_issue_scheduler_if.slave  bus
);
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_MUL  = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    // Queue occupancy as a state, so q1 valid can only exist alongside q0 valid.
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_TWO   = 2'd2
    } qstate_t;

    qstate_t     qs;
    qstate_t     qs_next;
    logic [31:0] q0_ir;
    logic [31:0] q1_ir;
    logic        q0_v;
    logic        q1_v;

    logic [CNT_W-1:0] cnt [32];
    logic [31:0]      busy;

    logic [5:0]  op0;
    logic [5:0]  op1;
    logic [4:0]  rs0;
    logic [4:0]  rt0;
    logic [4:0]  rd0;
    logic [4:0]  rs1;
    logic [4:0]  rt1;
    logic [4:0]  rd1;
    logic [4:0]  dst0;
    logic [4:0]  dst1;
    logic        hasd0;
    logic        hasd1;
    logic        rtsrc0;
    logic        rtsrc1;
    logic        mul0;
    logic        mul1;
    logic        hz0;
    logic        hz1;
    logic        raw01;
    logic        waw01;
    logic [CNT_W-1:0] lat0;
    logic [CNT_W-1:0] lat1;

    logic        accept;
    logic        issue0;
    logic        issue1;

    logic        iss0_valid_r;
    logic        iss1_valid_r;
    logic [31:0] iss0_ir_r;
    logic [31:0] iss1_ir_r;
    logic        hz_stall_r;

    assign q0_v = (qs != Q_EMPTY);
    assign q1_v = (qs == Q_TWO);

    assign op0 = q0_ir[31:26];
    assign rs0 = q0_ir[25:21];
    assign rt0 = q0_ir[20:16];
    assign rd0 = q0_ir[15:11];
    assign op1 = q1_ir[31:26];
    assign rs1 = q1_ir[25:21];
    assign rt1 = q1_ir[20:16];
    assign rd1 = q1_ir[15:11];

    always_comb begin
        busy = '0;
        for (int unsigned r = 0; r < 32; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    // ADDI writes rt and reads only rs; unknown opcodes read rs/rt and write nothing.
    always_comb begin
        mul0   = (op0 == OP_MUL);
        mul1   = (op1 == OP_MUL);
        rtsrc0 = (op0 != OP_ADDI);
        rtsrc1 = (op1 != OP_ADDI);
        dst0   = (op0 == OP_ADDI) ? rt0 : rd0;
        dst1   = (op1 == OP_ADDI) ? rt1 : rd1;
        hasd0  = ((op0 == OP_ADD) || (op0 == OP_SUB) || mul0 || (op0 == OP_ADDI)) && (dst0 != 5'd0);
        hasd1  = ((op1 == OP_ADD) || (op1 == OP_SUB) || mul1 || (op1 == OP_ADDI)) && (dst1 != 5'd0);
        lat0   = mul0 ? MUL_CNT : ALU_CNT;
        lat1   = mul1 ? MUL_CNT : ALU_CNT;
    end

    always_comb begin
        hz0    = busy[rs0] | (rtsrc0 & busy[rt0]) | (hasd0 & busy[dst0]);
        hz1    = busy[rs1] | (rtsrc1 & busy[rt1]) | (hasd1 & busy[dst1]);
        raw01  = hasd0 & ((rs1 == dst0) | (rtsrc1 & (rt1 == dst0)));
        waw01  = hasd0 & hasd1 & (dst1 == dst0);
        accept = bus.pair_valid & ~q0_v & ~bus.flush;
        issue0 = q0_v & ~bus.stall_in & ~bus.flush & ~hz0;
        issue1 = issue0 & q1_v & ~hz1 & ~raw01 & ~waw01 & ~(mul0 & mul1);
    end

    always_comb begin
        qs_next = qs;
        if (bus.flush) begin
            qs_next = Q_EMPTY;
        end else if (accept) begin
            qs_next = bus.instr1_valid ? Q_TWO : Q_ONE;
        end else if (issue1) begin
            qs_next = Q_EMPTY;
        end else if (issue0) begin
            qs_next = (qs == Q_TWO) ? Q_ONE : Q_EMPTY;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            qs <= Q_EMPTY;
        end else begin
            qs <= qs_next;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            q0_ir <= '0;
            q1_ir <= '0;
        end else if (accept) begin
            q0_ir <= bus.instr0;
            q1_ir <= bus.instr1;
        end else if (issue0 && !issue1) begin
            q0_ir <= q1_ir;
        end
    end

    // Counters keep running through flush: older writes are still in flight.
    always_ff @(posedge clk1) begin
        for (int unsigned r = 0; r < 32; r++) begin
            if (reset) begin
                cnt[r] <= '0;
            end else if (issue0 && hasd0 && (dst0 == 5'(r))) begin
                cnt[r] <= lat0;
            end else if (issue1 && hasd1 && (dst1 == 5'(r))) begin
                cnt[r] <= lat1;
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            iss0_valid_r <= 1'b0;
            iss1_valid_r <= 1'b0;
            iss0_ir_r    <= '0;
            iss1_ir_r    <= '0;
            hz_stall_r   <= 1'b0;
        end else begin
            iss0_valid_r <= issue0;
            iss1_valid_r <= issue1;
            hz_stall_r   <= q0_v & ~issue0 & ~bus.flush;
            if (issue0) begin
                iss0_ir_r <= q0_ir;
            end
            if (issue1) begin
                iss1_ir_r <= q1_ir;
            end
        end
    end

    assign bus.pair_ready = ~q0_v;
    assign bus.iss0_valid = iss0_valid_r;
    assign bus.iss1_valid = iss1_valid_r;
    assign bus.iss0_ir    = iss0_ir_r;
    assign bus.iss1_ir    = iss1_ir_r;
    assign bus.hz_stall   = hz_stall_r;
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboarded bench for dual_issue_scheduler: each cycle's expected outputs are
// queued as stimulus is driven and checked on the following falling edge.
module tb_dual_issue_scheduler;
    logic clk1 = 1'b0;
    logic reset = 1'b1;

    always #5 clk1 = ~clk1;

    dual_issue_scheduler_if bus ();

    dual_issue_scheduler #(
        .ALU_LAT (2),
        .MUL_LAT (4),
        .CNT_W   (3)
    ) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [31:0] I_A    = 32'h2001000A;  // ADDI R1,R0,10
    localparam logic [31:0] I_B    = 32'h20020014;  // ADDI R2,R0,20
    localparam logic [31:0] I_ADD5 = 32'h00222800;  // ADD  R5,R1,R2
    localparam logic [31:0] I_M1   = 32'h08A62000;  // MUL  R4,R5,R6
    localparam logic [31:0] I_M2   = 32'h09093800;  // MUL  R7,R8,R9
    localparam logic [31:0] I_S    = 32'h04801800;  // SUB  R3,R4,R0

    typedef struct packed {
        logic        v0;
        logic [31:0] ir0;
        logic        v1;
        logic [31:0] ir1;
        logic        hz;
        logic        rdy;
        logic        irchk;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   vectors = 0;
    int   miscompares = 0;

    always @(negedge clk1) begin
        if (sb.size() != 0) begin
            m = sb.pop_front();
            vectors++;
            if (bus.iss0_valid !== m.v0) begin
                miscompares++;
                $display("FAIL iss0_valid @%0t: got %b expected %b", $time, bus.iss0_valid, m.v0);
            end
            vectors++;
            if (bus.iss1_valid !== m.v1) begin
                miscompares++;
                $display("FAIL iss1_valid @%0t: got %b expected %b", $time, bus.iss1_valid, m.v1);
            end
            vectors++;
            if (bus.hz_stall !== m.hz) begin
                miscompares++;
                $display("FAIL hz_stall @%0t: got %b expected %b", $time, bus.hz_stall, m.hz);
            end
            vectors++;
            if (bus.pair_ready !== m.rdy) begin
                miscompares++;
                $display("FAIL pair_ready @%0t: got %b expected %b", $time, bus.pair_ready, m.rdy);
            end
            if (m.v0 || m.irchk) begin
                vectors++;
                if (bus.iss0_ir !== m.ir0) begin
                    miscompares++;
                    $display("FAIL iss0_ir @%0t: got %h expected %h", $time, bus.iss0_ir, m.ir0);
                end
            end
            if (m.v1 || m.irchk) begin
                vectors++;
                if (bus.iss1_ir !== m.ir1) begin
                    miscompares++;
                    $display("FAIL iss1_ir @%0t: got %h expected %h", $time, bus.iss1_ir, m.ir1);
                end
            end
        end
    end

    // Queue the expectation for the coming edge, then move to just after it.
    task automatic tick(input logic v0, input logic [31:0] ir0, input logic v1,
                        input logic [31:0] ir1, input logic hz, input logic rdy,
                        input logic irchk);
        exp_t e;
        e.v0 = v0; e.ir0 = ir0; e.v1 = v1; e.ir1 = ir1;
        e.hz = hz; e.rdy = rdy; e.irchk = irchk;
        sb.push_back(e);
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    // Present a pair into an empty queue; it is accepted on this edge.
    task automatic send(input logic [31:0] i0, input logic [31:0] i1, input logic v1);
        bus.pair_valid   = 1'b1;
        bus.instr0       = i0;
        bus.instr1       = i1;
        bus.instr1_valid = v1;
        tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        bus.pair_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.flush        = 1'b0;
        bus.stall_in     = 1'b0;
        bus.pair_valid   = 1'b0;
        bus.instr0       = '0;
        bus.instr1       = '0;
        bus.instr1_valid = 1'b0;
        tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_independent();
        send(I_A, I_B, 1'b1);
        tick(1'b1, I_A, 1'b1, I_B, 1'b0, 1'b1, 1'b0);
        idle(1);
        vectors++;
        if (bus.pair_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL indep_ready_after: got %b expected 1", bus.pair_ready);
        end
    endtask

    task automatic test_raw();
        send(I_A, I_ADD5, 1'b1);
        tick(1'b1, I_A, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, I_ADD5, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(2);
    endtask

    task automatic test_structural();
        send(I_M1, I_M2, 1'b1);
        tick(1'b1, I_M1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, I_M2, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(4);
    endtask

    task automatic test_mul_latency();
        send(I_M1, '0, 1'b0);
        tick(1'b1, I_M1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        send(I_S, '0, 1'b0);
        tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, I_S, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic test_stall();
        send(I_A, I_B, 1'b1);
        bus.stall_in = 1'b1;
        tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        bus.stall_in = 1'b0;
        tick(1'b1, I_A, 1'b1, I_B, 1'b0, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic test_flush();
        // Blocked pair with q1 valid is dropped; a pair offered during flush is refused.
        send(I_M1, '0, 1'b0);
        tick(1'b1, I_M1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        send(I_S, I_B, 1'b1);
        bus.flush        = 1'b1;
        bus.pair_valid   = 1'b1;
        bus.instr0       = I_A;
        bus.instr1       = I_B;
        bus.instr1_valid = 1'b1;
        tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        bus.flush        = 1'b0;
        bus.pair_valid   = 1'b0;
        idle(3);
        // Counter survives flush, so the refetched dependent still waits.
        send(I_M1, I_S, 1'b1);
        tick(1'b1, I_M1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        bus.flush = 1'b0;
        send(I_S, '0, 1'b0);
        tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, I_S, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        send(I_M1, I_S, 1'b1);
        tick(1'b1, I_M1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        send(I_S, '0, 1'b0);
        tick(1'b1, I_S, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_structural();
        test_mul_latency();
        test_stall();
        test_flush();
        test_reset_mid();
        @(negedge clk1);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary in time");
        $fatal(1, "timeout");
    end
endmodule
